// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 8;

  function automatic logic [3:0] size_bytes(size_t s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store request-response bus between the core (master) and the data memory (slave).
interface dmem_if;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  dmem_pkg::size_t   req_size;
  logic              req_unsigned;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for a little-endian 64-bit word: load extract/extend and store merge.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  lane,
  input  size_t       size,
  input  logic        is_unsigned,
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_word
);

  logic [63:0] shifted;
  logic [63:0] wshift;
  logic [63:0] bmask64;
  logic [7:0]  lanes;
  logic [7:0]  bmask;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    wshift  = wdata << {lane, 3'b000};
    case (size)
      SZ_BYTE: begin
        lanes     = 8'h01;
        load_data = is_unsigned ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        lanes     = 8'h03;
        load_data = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        lanes     = 8'h0F;
        load_data = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      default: begin
        lanes     = 8'hFF;
        load_data = shifted;
      end
    endcase
    bmask = lanes << lane;
    for (int b = 0; b < 8; b++) begin
      bmask64[8*b +: 8] = {8{bmask[b]}};
    end
    store_word = (word & ~bmask64) | (wshift & bmask64);
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, byte-lane read/write.
// Define DMEM_ACCESS_COUNT_EN to add rd_count/wr_count/err_count access counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] err_count
`endif
);

  localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          CNT_W = $clog2(WAIT_CYCLES + 2);
  localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) * 64'(BYTES_PER_WORD);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, rsp_done, enter_resp;

  logic               lat_write, lat_unsigned;
  size_t              lat_size;
  logic [63:0]        lat_addr, lat_wdata;
  logic               cur_write, cur_unsigned, cur_err, misaligned;
  size_t              cur_size;
  logic [63:0]        cur_addr, cur_wdata;

  logic [63:0]        mem [DEPTH_WORDS];
  logic [AW-1:0]      widx;
  logic [63:0]        rd_word, load_data, store_word;

  assign accept   = bus.req_valid & bus.req_ready;
  assign rsp_done = bus.rsp_valid & bus.rsp_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access resolves on the accept edge, so use the live bus fields.
  assign cur_write    = (state_q == IDLE) ? bus.req_write    : lat_write;
  assign cur_size     = (state_q == IDLE) ? bus.req_size     : lat_size;
  assign cur_unsigned = (state_q == IDLE) ? bus.req_unsigned : lat_unsigned;
  assign cur_addr     = (state_q == IDLE) ? bus.req_addr     : lat_addr;
  assign cur_wdata    = (state_q == IDLE) ? bus.req_wdata    : lat_wdata;

  assign misaligned = |(cur_addr[2:0] & 3'(size_bytes(cur_size) - 4'd1));
  assign cur_err    = misaligned | (cur_addr >= LIMIT);
  assign widx       = cur_addr[AW+2:3];
  assign rd_word    = mem[widx];

  dmem_lane_align u_align (
    .lane        (cur_addr[2:0]),
    .size        (cur_size),
    .is_unsigned (cur_unsigned),
    .word        (rd_word),
    .wdata       (cur_wdata),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus.req_ready <= (state_d == IDLE);
      bus.rsp_valid <= (state_d == RESP);
      if (enter_resp) begin
        bus.rsp_err   <= cur_err;
        bus.rsp_rdata <= (cur_err | cur_write) ? 64'd0 : load_data;
      end else if (rsp_done) begin
        bus.rsp_err   <= 1'b0;
        bus.rsp_rdata <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write    <= bus.req_write;
      lat_size     <= bus.req_size;
      lat_unsigned <= bus.req_unsigned;
      lat_addr     <= bus.req_addr;
      lat_wdata    <= bus.req_wdata;
    end
  end

  // Array is deliberately unreset; a store commits only on the RESP-entry edge.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_write && !cur_err) mem[widx] <= store_word;
  end

`ifdef DMEM_ACCESS_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (enter_resp) begin
      if (cur_err)        err_count <= err_count + 32'd1;
      else if (cur_write) wr_count  <= wr_count + 32'd1;
      else                rd_count  <= rd_count + 32'd1;
    end
  end
`endif

endmodule
